regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Parametrised 2-read/2-write CPU register file with write-to-read bypass and
//  a per-register pending-write scoreboard. Sits in ID: serves operand reads,
//  accepts WB writes on two ports, and flags operands whose producer is still
//  in flight so hazard logic can stall.
// PARAMETERS
//  DW       32  data width of each register
//  AW       5   address width; depth = 2**AW registers
//  ZERO_REG 1   1: register 0 reads as 0, ignores writes, never busy
//  RST_VAL  1   value loaded into every register on reset (DW bits)
// PORTS
//  clk     in   1   clock, rising edge
//  clrn    in   1   reset, asynchronous, active-low
//  rna     in   AW  read address A
//  rnb     in   AW  read address B
//  qa      out  DW  read data A (combinational)
//  qb      out  DW  read data B (combinational)
//  busy_a  out  1   register rna has a pending write
//  busy_b  out  1   register rnb has a pending write
//  we0     in   1   write enable, port 0 (clears scoreboard)
//  wn0     in   AW  write address, port 0
//  d0      in   DW  write data, port 0
//  we1     in   1   write enable, port 1 (no scoreboard effect)
//  wn1     in   AW  write address, port 1
//  d1      in   DW  write data, port 1
//  iss_v   in   1   instruction issued; marks iss_wn pending
//  iss_wn  in   AW  destination register of issued instruction
//  sb_any  out  1   OR of all scoreboard bits
// BEHAVIOUR
//  - Reset (clrn=0, async): every register = RST_VAL, all busy bits = 0.
//    Outputs during reset: qa/qb = RST_VAL (0 for addr 0 if ZERO_REG),
//    busy_a/busy_b/sb_any = 0. Writes and issues ignored while clrn=0.
//  - Writes take effect on rising clk when weN=1. If ZERO_REG, wnN=0 ignored.
//  - Same-address conflict: we0 & we1 & wn0==wn1 -> port 1 data stored.
//  - Read bypass (zero latency): if a write to rna is enabled this cycle, qa =
//    that write data (port 1 over port 0), else stored value. Same for qb.
//    Address 0 with ZERO_REG always reads 0, bypass included.
//  - Scoreboard bit busy[r] per register, updated on rising clk:
//    set when iss_v & iss_wn==r; cleared when we0 & wn0==r;
//    set and clear same cycle/same r -> bit stays 1 (new issue wins).
//    ZERO_REG: busy[0] constant 0.
//  - busy_a = busy[rna] & ~(we0 & wn0==rna); busy_b likewise. Operand written
//    this cycle on port 0 is bypassed, so no stall. Port 1 does not mask busy.
//  - sb_any = |busy (registered bits only, no masking).
//  - Reset mid-operation: contents and scoreboard return to reset state at
//    once; an in-progress write in that cycle is lost.
// TESTING
//  1 Reset with clrn=0: rna=5 -> qa=1; rna=0 -> qa=0; sb_any=0.
//  2 we0=1,wn0=3,d0=32'hDEAD_BEEF, rna=3 same cycle -> qa=DEADBEEF (bypass);
//    next cycle we0=0 -> qa still DEADBEEF.
//  3 we0,we1 both wn=7, d0=32'h11, d1=32'h22 -> qb=22 same cycle, reg7=22 after.
//  4 iss_v=1,iss_wn=9 -> next cycle busy_a=1 (rna=9), sb_any=1; then we0=1,
//    wn0=9 -> busy_a=0 same cycle, busy[9]=0 after edge, sb_any=0.
//  5 Same cycle iss_v,iss_wn=4 and we0,wn0=4 -> busy[4]=1 after edge.
//  6 we1=1,wn1=0,d1=5 and iss_v,iss_wn=0 -> qa(rna=0)=0, busy_a=0; pulse clrn
//    low mid-sequence with busy bits set -> all busy 0, regs = RST_VAL at once.

Source files
------------

// File: rtl/regfile_sb.sv
// 2-read/2-write register file with same-cycle write bypass and a per-register
// pending-write scoreboard used by ID-stage hazard logic to stall dependent operands.
module regfile_sb #(
  parameter int              DW       = 32,
  parameter int              AW       = 5,
  parameter bit              ZERO_REG = 1'b1,
  parameter logic [DW-1:0]   RST_VAL  = DW'(1)
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic [AW-1:0] rna,
  input  logic [AW-1:0] rnb,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb,
  output logic          busy_a,
  output logic          busy_b,
  input  logic          we0,
  input  logic [AW-1:0] wn0,
  input  logic [DW-1:0] d0,
  input  logic          we1,
  input  logic [AW-1:0] wn1,
  input  logic [DW-1:0] d1,
  input  logic          iss_v,
  input  logic [AW-1:0] iss_wn,
  output logic          sb_any
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0]    regs [DEPTH];
  logic [DEPTH-1:0] busy;

  // Writes and issues are gated by clrn so nothing bypasses or commits while
  // the file is held in reset.
  logic we0_en, we1_en, iss_en;
  assign we0_en = we0 & clrn;
  assign we1_en = we1 & clrn;
  assign iss_en = iss_v & clrn;

  logic [DEPTH-1:0] wr0_hit, wr1_hit, clr_hit, iss_hit;

  // NOTE: every output of an always_comb gets a default first so no path
  // through the block leaves a value unassigned and infers a latch.
  always_comb begin
    wr0_hit = '0;
    wr1_hit = '0;
    clr_hit = '0;
    iss_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!(ZERO_REG && i == 0)) begin
        wr0_hit[i] = we0_en && (wn0 == AW'(i));
        wr1_hit[i] = we1_en && (wn1 == AW'(i));
        clr_hit[i] = we0_en && (wn0 == AW'(i));
        iss_hit[i] = iss_en && (iss_wn == AW'(i));
      end
    end
  end

  // NOTE: this array is built from flops, not a RAM macro, so it can take an
  // async reset to RST_VAL; state updates use non-blocking assignments so all
  // registers sample the same pre-edge values.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= RST_VAL;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr1_hit[i])      regs[i] <= d1;
        else if (wr0_hit[i]) regs[i] <= d0;
      end
    end
  end

  // A new issue to the same register outranks the retiring port-0 write.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) busy <= '0;
    else       busy <= (busy & ~clr_hit) | iss_hit;
  end

  // Read path: port 1 has priority over port 0, register 0 overrides everything.
  always_comb begin
    qa = regs[rna];
    if (we0_en && wn0 == rna) qa = d0;
    if (we1_en && wn1 == rna) qa = d1;
    if (ZERO_REG && rna == '0) qa = '0;

    qb = regs[rnb];
    if (we0_en && wn0 == rnb) qb = d0;
    if (we1_en && wn1 == rnb) qb = d1;
    if (ZERO_REG && rnb == '0) qb = '0;
  end

  // Port 0 retires the pending write and its data is bypassed, so no stall.
  assign busy_a = busy[rna] & ~(we0_en && wn0 == rna);
  assign busy_b = busy[rnb] & ~(we0_en && wn0 == rnb);
  assign sb_any = |busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed cases for bypass, conflicts, scoreboard and
// reset, then randomized traffic checked against an array-based reference model.
module tb_regfile_sb;

  localparam int          DW      = 32;
  localparam int          AW      = 5;
  localparam int          DEPTH   = 32;
  localparam logic [31:0] RST_VAL = 32'd1;

  logic          clk, clrn;
  logic [AW-1:0] rna, rnb, wn0, wn1, iss_wn;
  logic [DW-1:0] qa, qb, d0, d1;
  logic          busy_a, busy_b, we0, we1, iss_v, sb_any;

  regfile_sb #(.DW(DW), .AW(AW), .ZERO_REG(1'b1), .RST_VAL(RST_VAL)) dut (
    .clk(clk), .clrn(clrn), .rna(rna), .rnb(rnb), .qa(qa), .qb(qb),
    .busy_a(busy_a), .busy_b(busy_b), .we0(we0), .wn0(wn0), .d0(d0),
    .we1(we1), .wn1(wn1), .d1(d1), .iss_v(iss_v), .iss_wn(iss_wn),
    .sb_any(sb_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] m_regs [DEPTH];
  bit          m_busy [DEPTH];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = RST_VAL;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic logic [31:0] exp_q(input logic [AW-1:0] a);
    if (a == 0) return 32'd0;
    if (!clrn) return m_regs[a];
    if (we1 && wn1 == a) return d1;
    if (we0 && wn0 == a) return d0;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (!clrn) return 1'b0;
    return m_busy[a] && !(we0 && wn0 == a);
  endfunction

  function automatic logic exp_any();
    for (int i = 0; i < DEPTH; i++) if (m_busy[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Sequential application of the writes gives port 1 the last word and the
  // issue the last word on the scoreboard.
  task automatic model_commit();
    if (we0 && wn0 != 0) m_regs[wn0] = d0;
    if (we1 && wn1 != 0) m_regs[wn1] = d1;
    if (we0) m_busy[wn0] = 1'b0;
    if (iss_v && iss_wn != 0) m_busy[iss_wn] = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_qa"},     qa,     exp_q(rna));
    check({tag, "_qb"},     qb,     exp_q(rnb));
    check({tag, "_busy_a"}, busy_a, exp_busy(rna));
    check({tag, "_busy_b"}, busy_b, exp_busy(rnb));
    check({tag, "_sb_any"}, sb_any, exp_any());
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; iss_v = 0;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    if (clrn) model_commit();
    @(negedge clk);
  endtask

  task automatic step(input string tag);
    settle();
    check_outputs(tag);
    tick();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    clrn = 0; idle();
    rna = 5; rnb = 0; wn0 = 0; wn1 = 0; iss_wn = 0; d0 = 0; d1 = 0;
    model_reset();
    @(negedge clk);

    // Reset state, including a write request that must be ignored.
    settle();
    check("rst_qa5", qa, 32'd1);
    check("rst_qb0", qb, 32'd0);
    check("rst_sb_any", sb_any, 1'b0);
    we0 = 1; wn0 = 5; d0 = 32'hAAAA_AAAA;
    #1;
    check("rst_no_bypass", qa, 32'd1);
    tick();
    idle();
    check("rst_no_write", qa, 32'd1);
    clrn = 1;
    step("post_rst");

    // Bypass on port 0, then the stored value.
    we0 = 1; wn0 = 3; d0 = 32'hDEAD_BEEF; rna = 3;
    settle();
    check("t2_bypass", qa, 32'hDEAD_BEEF);
    check_outputs("t2a");
    tick();
    idle();
    settle();
    check("t2_stored", qa, 32'hDEAD_BEEF);
    check_outputs("t2b");
    tick();

    // Same-address conflict: port 1 wins.
    we0 = 1; we1 = 1; wn0 = 7; wn1 = 7; d0 = 32'h11; d1 = 32'h22; rnb = 7;
    settle();
    check("t3_bypass", qb, 32'h22);
    tick();
    idle();
    settle();
    check("t3_stored", qb, 32'h22);
    check_outputs("t3");
    tick();

    // Scoreboard set by issue, masked and cleared by a port-0 write.
    iss_v = 1; iss_wn = 9; rna = 9;
    step("t4a");
    idle();
    settle();
    check("t4_busy_set", busy_a, 1'b1);
    check("t4_any_set", sb_any, 1'b1);
    tick();
    we0 = 1; wn0 = 9; d0 = 32'h99;
    settle();
    check("t4_busy_masked", busy_a, 1'b0);
    check("t4_any_still", sb_any, 1'b1);
    tick();
    idle();
    settle();
    check("t4_busy_clr", busy_a, 1'b0);
    check("t4_any_clr", sb_any, 1'b0);
    tick();

    // Issue and retire to the same register in one cycle: issue wins.
    iss_v = 1; iss_wn = 4; we0 = 1; wn0 = 4; d0 = 32'h44; rna = 4;
    step("t5a");
    idle();
    settle();
    check("t5_busy", busy_a, 1'b1);
    check_outputs("t5b");
    tick();

    // Register 0 is hardwired: no write, no bypass, never busy.
    we1 = 1; wn1 = 0; d1 = 5; iss_v = 1; iss_wn = 0; rna = 0;
    settle();
    check("t6_zero_q", qa, 32'd0);
    check("t6_zero_busy", busy_a, 1'b0);
    tick();
    idle();
    rnb = 4; rna = 3;
    settle();
    check("t6_zero_stays", busy_a, 1'b0);
    check("t6_b4_busy", busy_b, 1'b1);
    check("t6_any", sb_any, 1'b1);

    // Asynchronous reset in the middle of a cycle.
    clrn = 0;
    model_reset();
    #1;
    check("t6_rst_any", sb_any, 1'b0);
    check("t6_rst_busy_b", busy_b, 1'b0);
    check("t6_rst_qb", qb, 32'd1);
    check("t6_rst_qa", qa, 32'd1);
    #1;
    clrn = 1;
    tick();

    // Randomized traffic with occasional reset cycles.
    for (int n = 0; n < 600; n++) begin
      clrn   = ($urandom_range(0, 59) != 0);
      we0    = $urandom_range(0, 1);
      we1    = ($urandom_range(0, 2) == 0);
      iss_v  = $urandom_range(0, 1);
      wn0    = rand_addr();
      wn1    = ($urandom_range(0, 3) == 0) ? wn0 : rand_addr();
      iss_wn = ($urandom_range(0, 3) == 0) ? wn0 : rand_addr();
      rna    = ($urandom_range(0, 2) == 0) ? wn0 : rand_addr();
      rnb    = ($urandom_range(0, 2) == 0) ? wn1 : rand_addr();
      d0     = $urandom;
      d1     = $urandom;
      if (!clrn) model_reset();
      step("rnd");
    end

    // Final sweep of every register and scoreboard bit.
    clrn = 1;
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      rna = AW'(i);
      rnb = AW'(DEPTH - 1 - i);
      step("sweep");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
